// File: rtl/ndiv_seq_pkg.sv
// Shared types and constant helpers for the sequential Newton-Raphson divider.
// Operand width is limited to 64 bits by the helper functions below.
package ndiv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL_DX,
    MUL_XT,
    MUL_AX,
    CORR,
    DONE
  } state_t;

  localparam int unsigned CORR_MAX = 3;

  function automatic int unsigned lz_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  // 1.5 in UQ1.(n-1)
  function automatic logic [63:0] x_init(input int unsigned n);
    return 64'd3 << (n - 2);
  endfunction

  // Leading zeros within the low n bits of v; returns n when they are all zero.
  function automatic int unsigned lzc(input logic [63:0] v, input int unsigned n);
    int unsigned cnt;
    logic        seen;
    cnt  = 0;
    seen = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      if ((i < int'(n)) && !seen) begin
        if (v[i]) seen = 1'b1;
        else      cnt  = cnt + 1;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ndiv_seq_if.sv
// Operand/result handshake bundle of the divider.
// valid/ready: a transfer occurs on a rising clk edge where valid and ready are
// both high; the sender holds valid and its data stable until then, and ready
// never depends on valid in the same cycle.
interface ndiv_seq_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quot;
  logic [N-1:0] rem;
  logic         dz;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, quot, rem, dz
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, quot, rem, dz
  );
endinterface

// File: rtl/ndiv_seq_nmul.sv
// Unsigned N x N -> 2N multiplier shared by every step of the divider.
module ndiv_seq_nmul #(
  parameter int N = 32
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  assign p = {{N{1'b0}}, a} * {{N{1'b0}}, b};

endmodule

// File: rtl/ndiv_seq.sv
// Multi-cycle Newton-Raphson unsigned divider: one shared multiplier walks through
// reciprocal refinement, quotient estimate and a short +/-1 correction loop.
module ndiv_seq
  import ndiv_seq_pkg::*;
#(
  parameter int N    = 32,
  parameter int ITER = 5
) (
  input  logic       clk,
  input  logic       n_reset,
  ndiv_seq_if.slave  bus,
  output state_t     dbg_state,
  output logic [1:0] dbg_corr
);

  localparam int LZ_W   = lz_width(N);
  localparam int SH_W   = $clog2(2 * N);
  localparam int ITER_W = $clog2(ITER + 1);
  localparam logic [63:0]  X_INIT_W = x_init(N);
  localparam logic [N-1:0] X_INIT   = X_INIT_W[N-1:0];

  state_t              state_q, state_d;
  logic [N-1:0]        a_q, a_d;
  logic [N-1:0]        b_q, b_d;
  logic [N-1:0]        d_q, d_d;
  logic [N-1:0]        x_q, x_d;
  logic [N-1:0]        t_q, t_d;
  logic [LZ_W-1:0]     lz_q, lz_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [1:0]          corr_q, corr_d;
  logic [N-1:0]        quot_q, quot_d;
  logic [N-1:0]        rem_q, rem_d;
  logic                dz_q, dz_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;

  logic [N-1:0]        mul_a, mul_b;
  logic [2*N-1:0]      mul_p;
  logic [LZ_W-1:0]     lz_in;
  logic [N-1:0]        e_w;
  logic [SH_W-1:0]     sh_amt;
  logic [N-1:0]        quot_est;
  logic [2*N-1:0]      a_ext, b_ext, diff_w;
  logic [N-1:0]        rem_w;
  logic [ITER_W-1:0]   iter_nxt;

  ndiv_seq_nmul #(.N(N)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // Multiplier operands depend only on the state, never on the handshake.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      MUL_DX: begin mul_a = d_q;    mul_b = x_q; end
      MUL_XT: begin mul_a = x_q;    mul_b = t_q; end
      MUL_AX: begin mul_a = a_q;    mul_b = x_q; end
      CORR:   begin mul_a = quot_q; mul_b = b_q; end
      default: begin mul_a = '0;    mul_b = '0;  end
    endcase
  end

  assign lz_in    = LZ_W'(lzc(64'(bus.b), N));
  assign e_w      = mul_p[2*N-1:N];
  assign sh_amt   = SH_W'(2 * N - 1) - SH_W'(lz_q);
  assign quot_est = N'(mul_p >> sh_amt);
  assign a_ext    = {{N{1'b0}}, a_q};
  assign b_ext    = {{N{1'b0}}, b_q};
  assign diff_w   = a_ext - mul_p;
  assign rem_w    = a_q - mul_p[N-1:0];
  assign iter_nxt = iter_q + ITER_W'(1);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    d_d         = d_q;
    x_d         = x_q;
    t_d         = t_q;
    lz_d        = lz_q;
    iter_d      = iter_q;
    corr_d      = corr_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dz_d        = dz_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.a;
          b_d        = bus.b;
          lz_d       = lz_in;
          d_d        = bus.b << lz_in;
          x_d        = X_INIT;
          iter_d     = '0;
          in_ready_d = 1'b0;
          if (bus.b == '0) begin
            quot_d      = '1;
            rem_d       = bus.a;
            dz_d        = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            dz_d    = 1'b0;
            state_d = MUL_DX;
          end
        end
      end
      MUL_DX: begin
        // 2.0 - e: the 2^N term drops out of the N-bit result.
        t_d     = '0 - e_w;
        state_d = MUL_XT;
      end
      MUL_XT: begin
        x_d     = mul_p[2*N-1] ? '1 : mul_p[2*N-2:N-1];
        iter_d  = iter_nxt;
        state_d = (iter_nxt == ITER_W'(ITER)) ? MUL_AX : MUL_DX;
      end
      MUL_AX: begin
        quot_d  = quot_est;
        corr_d  = '0;
        state_d = CORR;
      end
      CORR: begin
        corr_d = corr_q + 2'd1;
        if (corr_q == 2'(CORR_MAX - 1)) begin
          rem_d       = rem_w;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (mul_p > a_ext) begin
          quot_d = quot_q - 1'b1;
        end else if ((diff_w >= b_ext) && (quot_q != '1)) begin
          quot_d = quot_q + 1'b1;
        end else begin
          rem_d       = rem_w;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      x_q         <= '0;
      t_q         <= '0;
      lz_q        <= '0;
      iter_q      <= '0;
      corr_q      <= '0;
      quot_q      <= '0;
      rem_q       <= '0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      d_q         <= d_d;
      x_q         <= x_d;
      t_q         <= t_d;
      lz_q        <= lz_d;
      iter_q      <= iter_d;
      corr_q      <= corr_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dz_q        <= dz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quot      = quot_q;
  assign bus.rem       = rem_q;
  assign bus.dz        = dz_q;
  assign dbg_state     = state_q;
  assign dbg_corr      = corr_q;

endmodule
